// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline control logic.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_MEM_WAIT,
        HZ_ERROR
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forward_sel.sv
// EX operand forwarding selector for a single source operand.
module forward_sel
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    fwd_sel_e sel;

    // The younger result in M shadows the older one in W; x0 is hard-wired zero.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && rd_m != REG_ZERO && rd_m == rs) begin
            sel = FWD_MEM;
        end else if (reg_write_w && rd_w != REG_ZERO && rd_w == rs) begin
            sel = FWD_WB;
        end
    end

    assign fwd = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer with forwarding, memory-wait handling and perf counters.
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic [4:0]       rd_m,
    input  logic [4:0]       rd_w,
    input  logic             load_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             pc_src_e,
    input  logic             mem_access_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    hz_state_e         state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              lw_stall;
    logic              st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w;
    logic [1:0]        fwd_a, fwd_b;

    forward_sel u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_a)
    );

    forward_sel u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd         (fwd_b)
    );

    assign lw_stall = load_e && rd_e != REG_ZERO && (rd_e == rs1_d || rd_e == rs2_d);

    // While M is blocked the whole pipe freezes and a bubble enters WB; E-stage hazards wait.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        st_f = 1'b0;
        st_d = 1'b0;
        st_e = 1'b0;
        st_m = 1'b0;
        fl_d = 1'b0;
        fl_e = 1'b0;
        fl_w = 1'b0;
        case (state)
            HZ_RUN: begin
                if (mem_access_m && !dmem_ready) begin
                    {st_f, st_d, st_e, st_m} = 4'b1111;
                    fl_w       = 1'b1;
                    state_next = HZ_MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    st_f = lw_stall;
                    st_d = lw_stall;
                    fl_e = lw_stall | pc_src_e;
                    fl_d = pc_src_e;
                end
            end
            HZ_MEM_WAIT: begin
                {st_f, st_d, st_e, st_m} = 4'b1111;
                fl_w = 1'b1;
                if (dmem_ready) begin
                    state_next = HZ_RUN;
                    wait_next  = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_next = HZ_ERROR;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            HZ_ERROR: begin
                {st_f, st_d, st_e, st_m} = 4'b1111;
                fl_w = 1'b1;
            end
            default: begin
                state_next = HZ_RUN;
                wait_next  = '0;
            end
        endcase
    end

    assign stall_f = rst_n & st_f;
    assign stall_d = rst_n & st_d;
    assign stall_e = rst_n & st_e;
    assign stall_m = rst_n & st_m;
    assign flush_d = rst_n & fl_d;
    assign flush_e = rst_n & fl_e;
    assign flush_w = rst_n & fl_w;
    assign fwd_a_e = rst_n ? fwd_a : 2'b00;
    assign fwd_b_e = rst_n ? fwd_b : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == HZ_ERROR) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Counters stick at all-ones rather than wrapping so long runs stay readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_f && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_d && flush_count != '1) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (short timeout, narrow counters).
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, reg_write_m, reg_write_w, pc_src_e, mem_access_m, dmem_ready;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          mem_err;
    logic [CW-1:0] stall_cycles, flush_count;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
    } exp_t;

    exp_t          exp_q[$];
    string         tag_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .rd_m         (rd_m),
        .rd_w         (rd_w),
        .load_e       (load_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .pc_src_e     (pc_src_e),
        .mem_access_m (mem_access_m),
        .dmem_ready   (dmem_ready),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        load_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        pc_src_e = 1'b0; mem_access_m = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic check_output();
        exp_t  e;
        exp_t  o;
        string t;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
             fwd_a_e, fwd_b_e, mem_err};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("[TB] FAIL %s: outputs {st,fl,fa,fb,err} observed %b expected %b", t, o, e);
        end
        checks++;
        assert (stall_cycles === exp_stall) else begin
            errors++;
            $error("[TB] FAIL %s stall_cycles: observed %0d expected %0d", t, stall_cycles, exp_stall);
        end
        checks++;
        assert (flush_count === exp_flush) else begin
            errors++;
            $error("[TB] FAIL %s flush_count: observed %0d expected %0d", t, flush_count, exp_flush);
        end
        if (rst_n && exp_stall != '1) exp_stall = exp_stall + CW'(e.st[3]);
        if (rst_n && exp_flush != '1) exp_flush = exp_flush + CW'(e.fl[2]);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input string tag, input logic [3:0] st, input logic [2:0] fl,
                                  input logic [1:0] fa, input logic [1:0] fb, input logic err);
        exp_q.push_back('{st: st, fl: fl, fa: fa, fb: fb, err: err});
        tag_q.push_back(tag);
        check_output();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        pc_src_e = 1'b1; load_e = 1'b1; rd_e = 5'd7; rs1_d = 5'd7;
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; mem_access_m = 1'b1;
        apply_stimulus("reset_quiet", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        clear_inputs();
        apply_stimulus("idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        reg_write_w = 1'b1; rd_w = 5'd5; rs2_e = 5'd3;
        apply_stimulus("fwd_m_priority", 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0);
        rd_m = 5'd0;
        apply_stimulus("fwd_w_when_rdm0", 4'b0000, 3'b000, 2'b01, 2'b00, 1'b0);
        rs1_e = 5'd0; rd_w = 5'd9; rs2_e = 5'd9;
        apply_stimulus("fwd_b_w", 4'b0000, 3'b000, 2'b00, 2'b01, 1'b0);
        rd_w = 5'd0; rs2_e = 5'd0;
        apply_stimulus("fwd_x0_never", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        clear_inputs();
        load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        apply_stimulus("lw_stall", 4'b1100, 3'b010, 2'b00, 2'b00, 1'b0);
        rd_e = 5'd0; rs2_d = 5'd0;
        apply_stimulus("lw_rd0", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        pc_src_e = 1'b1;
        apply_stimulus("branch_flush", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        apply_stimulus("after_branch", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        mem_access_m = 1'b1; dmem_ready = 1'b0;
        apply_stimulus("wait_enter", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        apply_stimulus("wait_1", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        pc_src_e = 1'b1; load_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
        apply_stimulus("wait_ignores_hz", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        pc_src_e = 1'b0; load_e = 1'b0; dmem_ready = 1'b1;
        apply_stimulus("wait_release", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        apply_stimulus("run_again", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        mem_access_m = 1'b1; dmem_ready = 1'b1;
        apply_stimulus("zero_wait", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        dmem_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            apply_stimulus("timeout_wait", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b0);
        end
        pc_src_e = 1'b1;
        apply_stimulus("error_state", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
        dmem_ready = 1'b1; pc_src_e = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus("error_sticky_sat", 4'b1111, 3'b001, 2'b00, 2'b00, 1'b1);
        end

        rst_n = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        dmem_ready = 1'b0; pc_src_e = 1'b1;
        apply_stimulus("reset_from_error", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        rst_n = 1'b1;
        clear_inputs();
        apply_stimulus("post_reset_idle", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);
        pc_src_e = 1'b1;
        apply_stimulus("post_reset_run", 4'b0000, 3'b110, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        apply_stimulus("post_reset_count", 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
